// File: rtl/lms_adapt_fir_pkg.sv
// Shared types and arithmetic helpers for the LMS adaptive FIR.
// Saturation works on a wide signed carrier so every internal width fits inside it.
package lms_adapt_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_ERROR  = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_CLR  = 2'd1,
        MAC_ACC  = 2'd2
    } mac_mode_e;

    localparam int SATW = 64;

    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

    function automatic int upd_shift(input int dw, input int mu_shift);
        return dw - 1 + mu_shift;
    endfunction

    // Clamp v into the signed dw-bit range; callers truncate the result to dw bits.
    function automatic logic signed [SATW-1:0] sat_val(input logic signed [SATW-1:0] v, input int dw);
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/lms_adapt_fir_if.sv
// Sample/result handshake bundle between the sample source, the LMS filter and the error consumer.
interface lms_adapt_fir_if #(parameter int DW = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xn;
    logic signed [DW-1:0] dn;
    logic                 adapt_en;
    logic                 clear_w;
    logic                 out_valid;
    logic signed [DW-1:0] yn;
    logic signed [DW-1:0] en;

    modport master (
        output in_valid, xn, dn, adapt_en, clear_w,
        input  in_ready, out_valid, yn, en
    );

    modport slave (
        input  in_valid, xn, dn, adapt_en, clear_w,
        output in_ready, out_valid, yn, en
    );
endinterface

// File: rtl/lms_adapt_fir_mac.sv
// Shared arithmetic unit: registered DWxDW product feeding either the filter accumulator
// or a saturating weight update (weight + scaled product).
module lms_adapt_fir_mac
    import lms_adapt_fir_pkg::*;
#(
    parameter int DW       = 16,
    parameter int MU_SHIFT = 8,
    parameter int ACCW     = 36
) (
    input  logic                   clk,
    input  logic                   reset,
    input  mac_mode_e              mode_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    input  logic signed [DW-1:0]   w_i,
    output logic signed [ACCW-1:0] acc_o,
    output logic signed [DW-1:0]   wupd_o
);
    localparam int SHIFT = upd_shift(DW, MU_SHIFT);

    logic signed [2*DW-1:0] p_q, p_d;
    logic signed [ACCW-1:0] acc_q, acc_d;

    // Product and accumulator next-state.
    always_comb begin
        p_d   = (2*DW)'(a_i) * (2*DW)'(b_i);
        acc_d = acc_q;
        case (mode_i)
            MAC_CLR: acc_d = '0;
            MAC_ACC: acc_d = acc_q + ACCW'(p_q);
            default: acc_d = acc_q;
        endcase
    end

    // Product and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= '0;
            acc_q <= '0;
        end else begin
            p_q   <= p_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o  = acc_q;
    assign wupd_o = DW'(sat_val(SATW'(w_i) + SATW'(p_q >>> SHIFT), DW));

endmodule

// File: rtl/lms_adapt_fir.sv
// Time-multiplexed LMS adaptive FIR: one shared multiplier walks the taps for the
// filter sum, then (optionally) walks them again for the weight update.
module lms_adapt_fir
    import lms_adapt_fir_pkg::*;
#(
    parameter int DW       = 16,
    parameter int TAPS     = 16,
    parameter int MU_SHIFT = 8,
    parameter int ACCW     = acc_width(DW, TAPS)
) (
    input  logic            clk,
    input  logic            reset,
    lms_adapt_fir_if.slave  bus
);
    localparam int KW = $clog2(TAPS + 1);
    localparam int IW = $clog2(TAPS);

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [DW-1:0] x_q [TAPS];
    logic signed [DW-1:0] x_d [TAPS];
    logic signed [DW-1:0] w_q [TAPS];
    logic signed [DW-1:0] w_d [TAPS];
    logic signed [DW-1:0] d_q, d_d;
    logic                 ad_q, ad_d;
    logic signed [DW-1:0] yn_q, yn_d;
    logic signed [DW-1:0] en_q, en_d;
    logic                 ov_q, ov_d;

    logic [IW-1:0]          idx_s;
    logic [IW-1:0]          idx_nxt_s;
    mac_mode_e              mac_mode_s;
    logic signed [DW-1:0]   mac_a_s;
    logic signed [DW-1:0]   mac_b_s;
    logic signed [ACCW-1:0] acc_s;
    logic signed [DW-1:0]   wupd_s;
    logic signed [DW-1:0]   y_sat_s;
    logic signed [DW-1:0]   e_sat_s;

    assign idx_s     = k_q[IW-1:0];
    assign idx_nxt_s = idx_s + IW'(1);
    assign y_sat_s   = DW'(sat_val(SATW'(acc_s >>> (DW - 1)), DW));
    assign e_sat_s   = DW'(sat_val(SATW'(d_q) - SATW'(y_sat_s), DW));

    lms_adapt_fir_mac #(
        .DW       (DW),
        .MU_SHIFT (MU_SHIFT),
        .ACCW     (ACCW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .mode_i (mac_mode_s),
        .a_i    (mac_a_s),
        .b_i    (mac_b_s),
        .w_i    (w_q[idx_s]),
        .acc_o  (acc_s),
        .wupd_o (wupd_s)
    );

    // FSM next-state, tap walk and datapath control.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x_d        = x_q;
        w_d        = w_q;
        d_d        = d_q;
        ad_d       = ad_q;
        yn_d       = yn_q;
        en_d       = en_q;
        ov_d       = 1'b0;
        mac_mode_s = MAC_HOLD;
        mac_a_s    = '0;
        mac_b_s    = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_w) begin
                    for (int i = 0; i < TAPS; i++) w_d[i] = '0;
                end else if (bus.in_valid) begin
                    for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
                    x_d[0]     = bus.xn;
                    d_d        = bus.dn;
                    ad_d       = bus.adapt_en;
                    k_d        = '0;
                    mac_mode_s = MAC_CLR;
                    state_d    = ST_FILTER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILTER: begin
                // k == TAPS is a drain cycle that folds in the last registered product.
                if (k_q != KW'(TAPS)) begin
                    mac_a_s = x_q[idx_s];
                    mac_b_s = w_q[idx_s];
                    k_d     = k_q + KW'(1);
                end else begin
                    k_d     = '0;
                    state_d = ST_ERROR;
                end
                if (k_q != '0) begin
                    mac_mode_s = MAC_ACC;
                end else begin
                    mac_mode_s = MAC_HOLD;
                end
            end
            ST_ERROR: begin
                yn_d    = y_sat_s;
                en_d    = e_sat_s;
                ov_d    = 1'b1;
                mac_a_s = e_sat_s;
                mac_b_s = x_q[0];
                k_d     = '0;
                state_d = ad_q ? ST_UPDATE : ST_IDLE;
            end
            ST_UPDATE: begin
                w_d[idx_s] = wupd_s;
                if (k_q < KW'(TAPS - 1)) begin
                    mac_a_s = en_q;
                    mac_b_s = x_q[idx_nxt_s];
                    k_d     = k_q + KW'(1);
                end else begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, delay line, weights and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '{default: '0};
            w_q     <= '{default: '0};
            d_q     <= '0;
            ad_q    <= 1'b0;
            yn_q    <= '0;
            en_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            w_q     <= w_d;
            d_q     <= d_d;
            ad_q    <= ad_d;
            yn_q    <= yn_d;
            en_q    <= en_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !bus.clear_w && !reset;
    assign bus.out_valid = ov_q;
    assign bus.yn        = yn_q;
    assign bus.en        = en_q;

endmodule

// File: tb/tb_lms_adapt_fir.sv
// Directed bench for lms_adapt_fir: hand-computed vectors, immediate assertions at each check.
module tb_lms_adapt_fir;
    localparam int DW   = 16;
    localparam int TAPS = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lms_adapt_fir_if #(.DW(DW)) bus ();

    lms_adapt_fir #(.DW(DW), .TAPS(TAPS), .MU_SHIFT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one sample, return outputs, edges to out_valid and edges until in_ready returns.
    task automatic run_sample(input logic signed [15:0] x, input logic signed [15:0] d, input logic ad,
                              output logic signed [15:0] y, output logic signed [15:0] e,
                              output int lat, output int busy);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.xn = x; bus.dn = d; bus.adapt_en = ad; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        y = bus.yn;
        e = bus.en;
        busy = -1;
        if (lat > 0) begin
            for (int i = lat; i <= 200; i++) begin
                if (bus.in_ready) begin
                    busy = i;
                    break;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] y, e;
        logic signed [15:0] y5 [2];
        logic signed [15:0] e5 [2];
        int lat, busy, n;
        int acc_cnt, first_acc, second_acc, ov_cnt;
        logic rdy;

        bus.in_valid = 1'b0; bus.xn = '0; bus.dn = '0; bus.adapt_en = 1'b0; bus.clear_w = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_yn", bus.yn, 0);
        check("rst_en", bus.en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Frozen adaptation with zero weights.
        run_sample(16'sd1000, 16'sd2000, 1'b0, y, e, lat, busy);
        check("frz_latency", lat, 18);
        check("frz_yn", y, 0);
        check("frz_en", e, 2000);
        check("frz_ready_back", busy, 18);
        run_sample(16'sd1000, 16'sd2000, 1'b0, y, e, lat, busy);
        check("frz_repeat_en", e, 2000);

        // Adaptation steps.
        run_sample(16'sd16384, 16'sd8192, 1'b1, y, e, lat, busy);
        check("adp1_en", e, 8192);
        check("adp1_yn", y, 0);
        check("adp1_ready_back", busy, 34);
        run_sample(16'sd16384, 16'sd8192, 1'b1, y, e, lat, busy);
        check("adp2_yn", y, 8);
        check("adp2_en", e, 8184);
        run_sample(16'sd16384, 16'sd0, 1'b0, y, e, lat, busy);
        check("adp3_yn_w31_w15", y, 23);
        check("adp3_en", e, -23);

        // Saturating drive: converge near full scale, then a full-scale negative target.
        for (int i = 0; i < 2000; i++) run_sample(16'sd32767, 16'sd32767, 1'b1, y, e, lat, busy);
        check("sat_converged", (y > 16'sd30000), 1);
        run_sample(16'sd32767, -16'sd32768, 1'b1, y, e, lat, busy);
        check("sat_en_clamped", e, -32768);
        check("sat_yn_high", (y > 16'sd30000), 1);

        // Zero the weights and flush the delay line.
        @(negedge clk);
        bus.clear_w = 1'b1;
        @(posedge clk); #1;
        bus.clear_w = 1'b0;
        for (int i = 0; i < TAPS; i++) run_sample(16'sd0, 16'sd0, 1'b0, y, e, lat, busy);
        check("flush_yn", y, 0);

        // in_valid held high; only values on ready edges (0 and 35) may enter x[].
        acc_cnt = 0; first_acc = -1; second_acc = -1; ov_cnt = 0;
        y5[0] = '0; y5[1] = '0; e5[0] = '0; e5[1] = '0;
        for (int c = 0; c < 69; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.adapt_en = 1'b1; bus.dn = 16'sd8192;
            bus.xn = (c == 0 || c == 35) ? 16'sd16384 : -16'sd16384;
            #1;
            rdy = bus.in_ready;
            if (rdy) begin
                if (acc_cnt == 0) first_acc = c;
                else if (acc_cnt == 1) second_acc = c;
                acc_cnt++;
            end
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (ov_cnt < 2) begin
                    y5[ov_cnt] = bus.yn;
                    e5[ov_cnt] = bus.en;
                end
                ov_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        check("hs_first_accept", first_acc, 0);
        check("hs_second_accept", second_acc, 35);
        check("hs_accept_count", acc_cnt, 2);
        check("hs_out_count", ov_cnt, 2);
        check("hs_yn0", y5[0], 0);
        check("hs_en0", e5[0], 8192);
        check("hs_yn1", y5[1], 8);
        check("hs_en1", e5[1], 8184);

        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("hs_idle_again", bus.in_ready, 1);

        // clear_w beats a simultaneous in_valid.
        @(negedge clk);
        bus.clear_w = 1'b1; bus.in_valid = 1'b1; bus.xn = 16'sd5000; bus.dn = 16'sd777; bus.adapt_en = 1'b0;
        #1;
        check("clr_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.clear_w = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("clr_no_accept", bus.in_ready, 1);
        check("clr_no_out", bus.out_valid, 0);
        run_sample(16'sd16384, 16'sd100, 1'b0, y, e, lat, busy);
        check("clr_yn", y, 0);
        check("clr_en", e, 100);

        // Reset in the middle of UPDATE.
        @(negedge clk);
        bus.xn = 16'sd16384; bus.dn = 16'sd8192; bus.adapt_en = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (23) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_en", bus.en, 0);
        check("mid_rst_yn", bus.yn, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", bus.in_ready, 1);
        run_sample(16'sd16384, 16'sd8192, 1'b0, y, e, lat, busy);
        check("post_rst_yn", y, 0);
        check("post_rst_en", e, 8192);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
